// File: rtl/det_event_counter.sv
// rtl/det_event_counter.sv - edge-to-event converter with BCD event count and LED stretcher
// Turns detector level rises into one-cycle events, counts them 00-99 in BCD, stretches them onto an LED.
module det_event_counter #(
  parameter int STRETCH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic       det_in,
  output logic       det_pulse,
  output logic [3:0] count_ones,
  output logic [3:0] count_tens,
  output logic       overflow,
  output logic       led
);

  localparam int SW = $clog2(STRETCH + 1);
  localparam logic [SW-1:0] SLOAD = SW'(STRETCH);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   scnt, scnt_nxt;
  logic            det_q;
  logic            ev;

  assign ev = en & det_in & ~det_q;

  // det_q tracks det_in through clr so a level held across clr cannot fake a new rise
  always_ff @(posedge clk) begin
    if (rst) det_q <= 1'b0;
    else     det_q <= det_in;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      det_pulse  <= 1'b0;
      count_ones <= 4'd0;
      count_tens <= 4'd0;
      overflow   <= 1'b0;
    end else if (ev) begin
      det_pulse <= 1'b1;
      if (count_ones == 4'd9) begin
        count_ones <= 4'd0;
        if (count_tens == 4'd9) begin
          count_tens <= 4'd0;
          overflow   <= 1'b1;
        end else begin
          count_tens <= count_tens + 4'd1;
        end
      end else begin
        count_ones <= count_ones + 4'd1;
      end
    end else begin
      det_pulse <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state <= IDLE;
      scnt  <= '0;
    end else begin
      state <= state_nxt;
      scnt  <= scnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    scnt_nxt  = scnt;
    case (state)
      IDLE: begin
        if (ev) begin
          state_nxt = HOLD;
          scnt_nxt  = SLOAD;
        end
      end
      HOLD: begin
        if (ev) begin
          scnt_nxt = SLOAD;
        end else begin
          scnt_nxt = scnt - SW'(1);
          if (scnt == SW'(1)) state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        scnt_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    led = (scnt != '0);
  end

endmodule

// File: tb/tb_det_event_counter.sv
// tb/tb_det_event_counter.sv - scoreboard bench for det_event_counter
// A behavioural model pushes expected outputs per edge; each scenario task drains and compares.
module tb_det_event_counter;

  localparam int STRETCH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic       det_in = 1'b0;
  logic       det_pulse;
  logic [3:0] count_ones;
  logic [3:0] count_tens;
  logic       overflow;
  logic       led;

  typedef struct packed {
    logic       pulse;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       ovf;
    logic       led;
  } obs_t;

  obs_t sb[$];
  obs_t act[$];

  int total = 0;
  int bad = 0;

  int   cyc = 0;
  int   m_cnt = 0;
  logic m_ovf = 1'b0;
  logic m_pulse = 1'b0;
  logic m_dq = 1'b0;
  int   m_last = -1000;

  det_event_counter #(.STRETCH(STRETCH)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clr        (clr),
    .det_in     (det_in),
    .det_pulse  (det_pulse),
    .count_ones (count_ones),
    .count_tens (count_tens),
    .overflow   (overflow),
    .led        (led)
  );

  always #5 clk = ~clk;

  task automatic capture();
    obs_t a;
    a = {det_pulse, count_tens, count_ones, overflow, led};
    act.push_back(a);
  endtask

  task automatic do_reset(input int n, input logic d);
    obs_t x;
    rst = 1'b1;
    det_in = d;
    for (int i = 0; i < n; i++) begin
      m_cnt = 0; m_ovf = 1'b0; m_pulse = 1'b0; m_dq = 1'b0; m_last = -1000;
      x = '0;
      sb.push_back(x);
      @(posedge clk); #1;
      cyc++;
      capture();
    end
    rst = 1'b0;
  endtask

  task automatic step(input logic d, input logic e, input logic c);
    obs_t x;
    logic ev;
    det_in = d; en = e; clr = c;
    ev = e && d && !m_dq;
    if (c) begin
      m_cnt = 0; m_ovf = 1'b0; m_pulse = 1'b0; m_last = -1000;
    end else begin
      m_pulse = ev;
      if (ev) begin
        m_cnt++;
        if (m_cnt == 100) begin
          m_cnt = 0;
          m_ovf = 1'b1;
        end
        m_last = cyc;
      end
    end
    m_dq = d;
    x.pulse = m_pulse;
    x.ones  = 4'(m_cnt % 10);
    x.tens  = 4'(m_cnt / 10);
    x.ovf   = m_ovf;
    x.led   = ((cyc - m_last) < STRETCH);
    sb.push_back(x);
    @(posedge clk); #1;
    cyc++;
    capture();
  endtask

  task automatic test_reset();
    obs_t e, a;
    int n_led = 0, n_pulse = 0;
    do_reset(2, 1'b1);
    total++;
    if ({det_pulse, count_tens, count_ones, overflow, led} !== 11'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=000", {det_pulse, count_tens, count_ones, overflow, led});
    end
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); a = act.pop_front();
      n_led += a.led; n_pulse += a.pulse;
      total++;
      if (a !== e) begin bad++; $display("FAIL sb_reset got=%h want=%h", a, e); end
    end
    total++;
    if (n_led != STRETCH) begin bad++; $display("FAIL reset_led_cycles got=%0d want=%0d", n_led, STRETCH); end
    total++;
    if (n_pulse != 1) begin bad++; $display("FAIL reset_pulse_count got=%0d want=1", n_pulse); end
  endtask

  task automatic test_held_level();
    obs_t e, a;
    int n_pulse = 0;
    step(1'b0, 1'b1, 1'b1);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
    end
    total++;
    if ({count_tens, count_ones} !== 8'h03) begin
      bad++; $display("FAIL held_count got=%h want=03", {count_tens, count_ones});
    end
    while (sb.size() > 0) begin
      e = sb.pop_front(); a = act.pop_front();
      n_pulse += a.pulse;
      total++;
      if (a !== e) begin bad++; $display("FAIL sb_held got=%h want=%h", a, e); end
    end
    total++;
    if (n_pulse != 3) begin bad++; $display("FAIL held_pulse_count got=%0d want=3", n_pulse); end
  endtask

  task automatic test_bcd_wrap();
    obs_t e, a;
    step(1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 101; i++) begin
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      if (i == 9) begin
        total++;
        if ({count_tens, count_ones, overflow} !== {8'h09, 1'b0}) begin
          bad++; $display("FAIL bcd_9 got=%h%h ovf=%b want=09 ovf=0", count_tens, count_ones, overflow);
        end
      end else if (i == 10) begin
        total++;
        if ({count_tens, count_ones} !== 8'h10) begin
          bad++; $display("FAIL bcd_10 got=%h%h want=10", count_tens, count_ones);
        end
      end else if (i == 100) begin
        total++;
        if ({count_tens, count_ones, overflow} !== {8'h00, 1'b1}) begin
          bad++; $display("FAIL bcd_100 got=%h%h ovf=%b want=00 ovf=1", count_tens, count_ones, overflow);
        end
      end else if (i == 101) begin
        total++;
        if ({count_tens, count_ones, overflow} !== {8'h01, 1'b1}) begin
          bad++; $display("FAIL bcd_101 got=%h%h ovf=%b want=01 ovf=1", count_tens, count_ones, overflow);
        end
      end
    end
    step(1'b0, 1'b1, 1'b1);
    total++;
    if ({count_tens, count_ones, overflow} !== {8'h00, 1'b0}) begin
      bad++; $display("FAIL bcd_clr got=%h%h ovf=%b want=00 ovf=0", count_tens, count_ones, overflow);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front(); a = act.pop_front();
      total++;
      if (a !== e) begin bad++; $display("FAIL sb_bcd got=%h want=%h", a, e); end
    end
  endtask

  task automatic test_enable();
    obs_t e, a;
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    total++;
    if ({count_tens, count_ones, det_pulse} !== 9'h000) begin
      bad++; $display("FAIL en_gated got=%h%h pulse=%b want=00 pulse=0", count_tens, count_ones, det_pulse);
    end
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    total++;
    if ({count_tens, count_ones} !== 8'h01) begin
      bad++; $display("FAIL en_count got=%h%h want=01", count_tens, count_ones);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front(); a = act.pop_front();
      total++;
      if (a !== e) begin bad++; $display("FAIL sb_enable got=%h want=%h", a, e); end
    end
  endtask

  task automatic test_clr_event();
    obs_t e, a;
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    total++;
    if ({count_tens, count_ones, det_pulse, led} !== 10'h000) begin
      bad++; $display("FAIL clr_with_ev got=%h%h pulse=%b led=%b want=00 0 0", count_tens, count_ones, det_pulse, led);
    end
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    total++;
    if (led !== 1'b0) begin bad++; $display("FAIL clr_mid_stretch led=%b want=0", led); end
    while (sb.size() > 0) begin
      e = sb.pop_front(); a = act.pop_front();
      total++;
      if (a !== e) begin bad++; $display("FAIL sb_clr got=%h want=%h", a, e); end
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, a;
    logic [7:0] lp = '0;
    int n_pulse = 0;
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); a = act.pop_front();
      lp = {lp[6:0], a.led};
      n_pulse += a.pulse;
      total++;
      if (a !== e) begin bad++; $display("FAIL sb_b2b got=%h want=%h", a, e); end
    end
    total++;
    if (lp !== 8'b1111_1100) begin bad++; $display("FAIL retrigger_led got=%b want=11111100", lp); end
    total++;
    if (n_pulse != 2 || {count_tens, count_ones} !== 8'h02) begin
      bad++; $display("FAIL b2b_count pulses=%0d cnt=%h%h want=2 02", n_pulse, count_tens, count_ones);
    end
  endtask

  task automatic test_rst_mid();
    obs_t e, a;
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    do_reset(1, 1'b0);
    total++;
    if ({det_pulse, count_tens, count_ones, overflow, led} !== 11'd0) begin
      bad++; $display("FAIL rst_mid got=%h want=000", {det_pulse, count_tens, count_ones, overflow, led});
    end
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); a = act.pop_front();
      total++;
      if (a !== e) begin bad++; $display("FAIL sb_rst_mid got=%h want=%h", a, e); end
    end
  endtask

  initial begin
    test_reset();
    test_held_level();
    test_bcd_wrap();
    test_enable();
    test_clr_event();
    test_back_to_back();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/det_event_counter.md
# det_event_counter

Downstream consumer of the 1101 Moore sequence detector's `out` level. It converts each detector assertion into a single-cycle event and counts events in a two-digit BCD counter (00–99, wrap with sticky overflow). It stretches each event onto an LED output so a human can see it on the board. It sits between the detector and the board's 7-segment/LED drivers, on the same clock.

## Interface
- `STRETCH`, 4: number of clock cycles `led` stays high after the most recent event; legal range ≥ 1.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `en`  input  1  count enable; when low, events are ignored.
- `clr`  input  1  synchronous clear of counts, overflow, stretch and pulse.
- `det_in`  input  1  detector output level (Moore `out`).
- `det_pulse`  output  1  registered one-cycle event strobe.
- `count_ones`  output  4  BCD ones digit, 0–9.
- `count_tens`  output  4  BCD tens digit, 0–9.
- `overflow`  output  1  sticky; set on the 99→00 wrap.
- `led`  output  1  stretched event indicator.

## Operation
- Internal `det_q` register: `det_q <= det_in` on every edge, regardless of `en` and `clr`. It is cleared only by `rst`.
- Event condition: `ev = en & det_in & ~det_q`, i.e. a rising edge of the detector level while enabled.
  - A level held high for N cycles counts once.
  - A level that rises while `en=0` never counts, even if `en` returns while it is still high.
- Priority on every edge: `rst` > `clr` > `ev`.
- `rst`: all outputs 0, `det_q` 0, stretch counter 0.
- `clr` (with `rst=0`):
  - `count_ones`, `count_tens`, `overflow`, `det_pulse` and the stretch counter go to 0.
  - `det_q` still samples `det_in`.
  - An `ev` on the same edge is discarded.
- On `ev` (no `rst`/`clr`):
  - `det_pulse <= 1`; otherwise `det_pulse <= 0`.
  - BCD increment:
    - if ones < 9, ones+1;
    - else ones=0 and tens+1;
    - if tens=9 and ones=9, both become 0 and `overflow <= 1`.
  - `overflow` stays 1 until `rst` or `clr`.
  - Digits never hold values 10–15.
- Stretch logic: two-state FSM with counter `scnt`, width `$clog2(STRETCH+1)`.
  - IDLE (`scnt`=0): on `ev`, load `scnt=STRETCH` and go to HOLD.
  - HOLD: on `ev`, reload `STRETCH` (retrigger). Otherwise decrement; reaching 0 returns to IDLE.
  - `led = (scnt != 0)`, decoded from a register, with no combinational path from inputs.

## Timing
- Reset value of every output is 0: `det_pulse`, `count_ones`, `count_tens`, `overflow`, `led`.
- Latency: `det_in` sampled 1 at edge k, with `det_q`=0 and `en`=1. After edge k:
  - `det_pulse`=1 for exactly one cycle;
  - the counts are already incremented;
  - `led`=1.
- `led` stays high for exactly `STRETCH` cycles after the last event edge. Back-to-back events extend it; there is no gap.
- Minimum event spacing: 2 cycles (det_in 1,0,1). Each rising edge counts, with no missed events.
- `det_in` high on the first edge after `rst` releases counts as an event, because `det_q` resets to 0.
- `clr` asserted mid-stretch: `led` drops to 0 on the next cycle.
- `rst` mid-operation behaves identically to power-on reset.
- All outputs are registered, so there are no input-to-output combinational paths.

## Test plan
- Reset: `rst`=1 for 2 cycles with `det_in`=1 → all outputs 0. Release with `det_in` held 1 → one event: count=01, `det_pulse` is 1 for 1 cycle, `led` high 4 cycles (STRETCH=4).
- Held level: `det_in` high for 5 cycles, then low, repeated 3 times with `en`=1 → count=03, and `det_pulse` asserted exactly 3 times, each 1 cycle wide.
- BCD carry and wrap:
  - 9 events → ones=9, tens=0;
  - 10th event → ones=0, tens=1;
  - 100 events total → count=00, `overflow`=1;
  - 101st event → 01, `overflow` still 1;
  - `clr` → 00, `overflow`=0.
- Enable gating:
  - `det_in` rises while `en`=0 and `en` goes 1 while `det_in` stays high → no count;
  - next rising edge with `en`=1 → count +1.
- Simultaneous events:
  - `clr` and an event on the same edge → count=00, `det_pulse`=0, `led`=0.
  - Retrigger: events at cycles 0 and 2 with STRETCH=4 → `led` high continuously for cycles 1–6.
